// File: rtl/forloop.sv
// Registered CRC-3 generator/checker over a 7-bit word, G(x) = x^3 + x + 1.
// The bit-serial LFSR is unrolled in one combinational loop, then registered.
module forloop #(
  parameter int unsigned      DATA_W = 7,
  parameter int unsigned      CRC_W  = 3,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(3'b011)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              gen_check,
  input  logic [CRC_W-1:0]  crc_in,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_error
);

  logic [CRC_W-1:0] crc_calc_c;
  logic             fb_c;
  logic             mismatch_c;

  // MSB-first LFSR, init 0, no reflection, no final XOR
  always_comb begin
    crc_calc_c = '0;
    fb_c       = 1'b0;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb_c       = data_in[i] ^ crc_calc_c[CRC_W-1];
      crc_calc_c = {crc_calc_c[CRC_W-2:0], 1'b0} ^ (fb_c ? POLY : '0);
    end
  end

  assign mismatch_c = (crc_calc_c != crc_in);

  // Error flag only meaningful in check mode; generate mode forces it low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_out   <= '0;
      crc_error <= 1'b0;
    end else begin
      crc_out   <= crc_calc_c;
      crc_error <= gen_check ? 1'b0 : mismatch_c;
    end
  end

endmodule

// File: tb/tb_forloop.sv
// Self-checking bench for forloop: directed cases plus randomized traffic
// against a polynomial long-division reference model.
module tb_forloop;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned CRC_W  = 3;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              gen_check;
  logic [CRC_W-1:0]  crc_in;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_error;

  int n_checks;
  int n_fail;

  forloop dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .gen_check (gen_check),
    .crc_in    (crc_in),
    .crc_out   (crc_out),
    .crc_error (crc_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of (d * x^3) divided by 1011 (x^3+x+1), plain long division
  function automatic logic [2:0] ref_crc(input logic [6:0] d);
    logic [9:0] v;
    v = {d, 3'b000};
    for (int k = 9; k >= 3; k--) begin
      if (v[k]) v = v ^ (10'b00_0000_1011 << (k - 3));
    end
    return v[2:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one word before an edge, then check the registered result after it
  task automatic apply(input string tag, input logic [6:0] d, input logic g, input logic [2:0] c);
    logic [2:0] exp_crc;
    @(negedge clk);
    data_in   = d;
    gen_check = g;
    crc_in    = c;
    @(posedge clk);
    #1;
    exp_crc = ref_crc(d);
    check({tag, "_crc"}, 32'(crc_out), 32'(exp_crc));
    check({tag, "_err"}, 32'(crc_error), g ? 32'd0 : 32'(exp_crc != c));
  endtask

  initial begin
    logic [6:0] d;
    logic [2:0] c;
    logic       g;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    data_in   = 7'h55;
    gen_check = 1'b0;
    crc_in    = 3'b111;

    // Reset holds outputs at zero across edges
    #3;
    check("rst_crc", 32'(crc_out), 32'd0);
    check("rst_err", 32'(crc_error), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_crc", 32'(crc_out), 32'd0);
    check("rst_hold_err", 32'(crc_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed generate-mode values
    apply("gen_1011000", 7'b1011000, 1'b1, 3'b111);
    apply("gen_0000001", 7'b0000001, 1'b1, 3'b000);
    apply("gen_1000000", 7'b1000000, 1'b1, 3'b000);
    apply("gen_0000011", 7'b0000011, 1'b1, 3'b000);
    check("const_0000011", 32'(crc_out), 32'd5);

    // Directed check-mode values
    apply("chk_ok", 7'b1011000, 1'b0, 3'b000);
    check("const_chk_ok", 32'(crc_error), 32'd0);
    apply("chk_flip", 7'b1011000, 1'b0, 3'b001);
    check("const_chk_flip", 32'(crc_error), 32'd1);
    apply("chk_ok2", 7'b1000000, 1'b0, 3'b100);
    apply("chk_dflip", 7'b1000001, 1'b0, 3'b100);
    check("const_chk_dflip", 32'(crc_error), 32'd1);

    // Mode toggling with a wrong crc_in, then reset mid-sequence
    for (int i = 0; i < 6; i++) begin
      apply("toggle", 7'b1011000, (i % 2) == 0, 3'b010);
    end
    @(negedge clk);
    data_in   = 7'b0000001;
    gen_check = 1'b0;
    crc_in    = 3'b000;
    #2 rst = 1'b1;
    #1;
    check("midrst_crc", 32'(crc_out), 32'd0);
    check("midrst_err", 32'(crc_error), 32'd0);
    @(posedge clk); #1;
    check("midrst_hold_crc", 32'(crc_out), 32'd0);
    check("midrst_hold_err", 32'(crc_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply("post_rst", 7'b0000001, 1'b0, 3'b000);

    // Every single-bit error on crc_in or data_in must be flagged
    for (int k = 0; k < 20; k++) begin
      d = 7'($urandom_range(0, 127));
      c = ref_crc(d);
      for (int b = 0; b < 3; b++) apply("sb_crc", d, 1'b0, c ^ 3'(1 << b));
      for (int b = 0; b < 7; b++) apply("sb_data", d ^ 7'(1 << b), 1'b0, c);
    end

    // Random traffic: mix of correct and random crc_in, random mode
    for (int k = 0; k < 300; k++) begin
      d = 7'($urandom_range(0, 127));
      g = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 1) == 1) ? ref_crc(d) : 3'($urandom_range(0, 7));
      apply("rand", d, g, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
